// File: rtl/alarm_melody_player_if.sv
// Ring-request / buzzer bundle between the alarm block and the melody player.
// master: alarm-block side (drives ring/stop); slave: melody player.
interface alarm_melody_player_if;
  logic       alarm_do;
  logic       stop;
  logic       buzzer;
  logic       busy;
  logic [3:0] note_idx;
  logic       song_done;

  modport master (
    output alarm_do, stop,
    input  buzzer, busy, note_idx, song_done
  );

  modport slave (
    input  alarm_do, stop,
    output buzzer, busy, note_idx, song_done
  );
endinterface

// File: rtl/alarm_melody_player.sv
// Plays a looping 16-note square-wave melody on buzzer while alarm_do is held
// and stop is low; any drop of the request returns to IDLE on the next cycle.
module alarm_melody_player #(
  parameter int unsigned CLK_HZ      = 1_000_000,
  parameter int unsigned BEAT_CYCLES = 250_000,
  parameter int unsigned GAP_CYCLES  = 10_000
) (
  input  logic                  newclk,
  input  logic                  rst,
  alarm_melody_player_if.slave  bus
);

  // Half-periods rounded up from note frequencies given in centi-hertz.
  localparam longint unsigned CHZ = longint'(CLK_HZ) * 100;
  localparam logic [15:0] HP_C5 = 16'((CHZ + 2 * 52325  - 1) / (2 * 52325));
  localparam logic [15:0] HP_E5 = 16'((CHZ + 2 * 65926  - 1) / (2 * 65926));
  localparam logic [15:0] HP_G5 = 16'((CHZ + 2 * 78399  - 1) / (2 * 78399));
  localparam logic [15:0] HP_C6 = 16'((CHZ + 2 * 104650 - 1) / (2 * 104650));

  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t      state;
  logic [15:0] hp;
  logic [15:0] tone_cnt;
  logic [31:0] beat_cnt;
  logic [1:0]  beats_left;
  logic        buzzer;
  logic        busy;
  logic [3:0]  note_idx;
  logic        song_done;

  logic [15:0] rom_hp;
  logic [1:0]  rom_beats;

  // Second half of the song repeats the first, so only the low index bits matter.
  always_comb begin
    rom_hp    = '0;
    rom_beats = 2'd1;
    case (note_idx[2:0])
      3'd0: begin rom_hp = HP_C5; rom_beats = 2'd1; end
      3'd1: begin rom_hp = HP_E5; rom_beats = 2'd1; end
      3'd2: begin rom_hp = HP_G5; rom_beats = 2'd1; end
      3'd3: begin rom_hp = HP_C6; rom_beats = 2'd2; end
      3'd4: begin rom_hp = '0;    rom_beats = 2'd1; end
      3'd5: begin rom_hp = HP_G5; rom_beats = 2'd1; end
      3'd6: begin rom_hp = HP_C6; rom_beats = 2'd2; end
      3'd7: begin rom_hp = '0;    rom_beats = 2'd3; end
      default: ;
    endcase
  end

  always_ff @(posedge newclk) begin
    if (rst) begin
      state      <= IDLE;
      hp         <= '0;
      tone_cnt   <= '0;
      beat_cnt   <= '0;
      beats_left <= '0;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
      note_idx   <= '0;
      song_done  <= 1'b0;
    end else begin
      song_done <= 1'b0;
      // Abort takes priority over every state action, including end-of-song.
      if (state != IDLE && (bus.stop || !bus.alarm_do)) begin
        state    <= IDLE;
        busy     <= 1'b0;
        buzzer   <= 1'b0;
        note_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.alarm_do && !bus.stop) begin
              state    <= LOAD;
              busy     <= 1'b1;
              note_idx <= '0;
            end
          end
          LOAD: begin
            hp         <= rom_hp;
            beats_left <= (rom_beats == 2'd0) ? 2'd0 : rom_beats - 2'd1;
            tone_cnt   <= '0;
            beat_cnt   <= '0;
            buzzer     <= 1'b0;
            state      <= PLAY;
          end
          PLAY: begin
            if (hp == '0) begin
              buzzer <= 1'b0;
            end else if (tone_cnt == hp - 16'd1) begin
              tone_cnt <= '0;
              buzzer   <= ~buzzer;
            end else begin
              tone_cnt <= tone_cnt + 16'd1;
            end
            // The GAP transition overrides any toggle on the last PLAY cycle.
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (beats_left == 2'd0) begin
                state  <= GAP;
                buzzer <= 1'b0;
              end else begin
                beats_left <= beats_left - 2'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
          GAP: begin
            buzzer <= 1'b0;
            if (beat_cnt == GAP_LAST) begin
              beat_cnt  <= '0;
              note_idx  <= note_idx + 4'd1;
              song_done <= (note_idx == 4'd15);
              state     <= LOAD;
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.buzzer    = buzzer;
  assign bus.busy      = busy;
  assign bus.note_idx  = note_idx;
  assign bus.song_done = song_done;

endmodule
